// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with multi-cycle data memory access and MEM/WB output registers.
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag and suppress out-of-range accesses via err.
module mem_stage #(
    parameter int WAIT_CYCLES = 3,
    parameter int DEPTH       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        wb_en_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] val_rm,
    output logic        freeze,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [3:0]  dest_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_data_out,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          req, oob, commit, rd;
    logic          wb_en_q, mem_r_en_q;
    logic [3:0]    dest_q;
    logic [31:0]   alu_q, data_q;

    assign req    = mem_r_en | mem_w_en;
    assign off    = alu_result - 32'd1024;
    assign idx    = AW'(off >> 2);
`ifdef MEM_BOUNDS_CHECK_EN
    assign oob    = (alu_result < 32'd1024) || ((off >> 2) >= 32'(DEPTH));
`else
    assign oob    = 1'b0;
`endif
    // Reset forces freeze low even while a request is presented.
    assign freeze = rst && ((state_q == IDLE && req) || state_q == ACCESS);
    // Simultaneous read and write is a load, so the store is dropped.
    assign commit = state_q == DONE && mem_w_en && !mem_r_en && !oob;
    assign rd     = state_q == DONE && mem_r_en && !oob;

    // Next-state and access-latency counter.
    always_comb begin
        state_d = state_q == IDLE   ? (req ? ACCESS : IDLE) :
                  state_q == ACCESS ? (cnt_q == 4'd0 ? DONE : ACCESS) : IDLE;
        cnt_d   = state_q == IDLE   ? (req ? 4'(WAIT_CYCLES - 1) : 4'd0) :
                  state_q == ACCESS ? (cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1) : 4'd0;
    end

    // FSM state and counter registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB registers: pass the instruction through when not frozen, else insert a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= 4'd0;
            alu_q      <= 32'd0;
            data_q     <= 32'd0;
        end else begin
            wb_en_q    <= !freeze && wb_en_in;
            mem_r_en_q <= !freeze && mem_r_en;
            dest_q     <= freeze ? 4'd0 : dest_in;
            alu_q      <= freeze ? 32'd0 : alu_result;
            data_q     <= rd ? mem_q[idx] : 32'd0;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic err_q;

    // Out-of-range flag accompanies the offending instruction for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= state_q == DONE && req && oob;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Data array, not reset; a store commits only on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (commit) mem_q[idx] <= val_rm;
    end

    assign wb_en_out      = wb_en_q;
    assign mem_r_en_out   = mem_r_en_q;
    assign dest_out       = dest_q;
    assign alu_result_out = alu_q;
    assign mem_data_out   = data_q;
endmodule
